alu_pipe_param: RTL
===================

# alu_pipe_param

Parametrised four-stage register/ALU/memory pipeline: each accepted instruction reads two registers, executes one of 16 ALU functions, writes the result back to the register bank and stores it to data memory. It is the single-clock successor to the two-phase `complex_pipeline`, with generic data width, register count and memory depth. It adds a valid/ready handshake with stall, per-stage valid bits, a register-initialisation port and a registered memory read port. Operand forwarding is compile-time selectable.

## Interface
Parameters:
- `DW`, 16, data width of registers, ALU and memory words
- `RA`, 4, register address bits (2^RA registers)
- `MA`, 8, memory address bits (2^MA words)

Ports:
- `clk` in 1 — single clock, all state updates on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `in_valid` in 1 — instruction present on `rs1/rs2/rd/func/addr`
- `in_ready` out 1 — `~hold`, combinational
- `hold` in 1 — freezes all stages
- `rs1`, `rs2`, `rd` in RA — source/destination register indices
- `func` in 4 — ALU function
- `addr` in MA — memory store address
- `z` out DW — S2 result register
- `z_valid` out 1 — `z` holds a valid result
- `cfg_we` in 1, `cfg_addr` in RA, `cfg_data` in DW — direct register-bank write
- `mem_raddr` in MA, `mem_rdata` out DW — memory read port, 1-cycle latency

## Operation
- Accept on a rising edge with `in_valid & in_ready`. Otherwise a bubble enters S1 (valid=0) unless `hold` is high.
- S1: latch operands A=R[rs1], B=R[rs2], plus `rd`, `func`, `addr`, valid.
- S2: latch `z`=ALU(A,B), `rd`, `addr`, valid.
- S3: R[rd] <= z when valid; pass `z`/`addr` on.
- S4: M[addr] <= z when valid.
- ALU, all results truncated to DW bits:
  - 0 A+B; 1 A−B (two's complement wrap); 2 A*B (low DW bits); 3 A; 4 B
  - 5 A&B; 6 A|B; 7 A^B; 8 −A; 9 −B
  - 10 A>>1 (logical); 11 A<<1; 12–15 result 0
- `hold`=1: every stage register keeps its value; regfile and memory writes are suppressed; nothing is accepted.
- Register-bank write conflict: if an S3 writeback and `cfg_we` target the same register on one edge, the S3 writeback wins and the cfg write is dropped. The cfg write to a different register proceeds.
- `cfg_we` is honoured regardless of `hold`.
- Reset clears all valid bits, `z`, and `mem_rdata`. Register bank and memory contents are not reset and are left unchanged.
- Reset mid-operation discards all in-flight instructions; no later writes occur from them.

## Timing
- Accept at edge k. `z` and `z_valid` appear after edge k+1 (latency 2). Register write at edge k+2. Memory write at edge k+3.
- Throughput: one instruction per cycle; no internal stalls.
- Reset values: `z`=0, `z_valid`=0, `mem_rdata`=0. `in_ready` follows `~hold` at all times, including during reset.
- `mem_rdata` = M[`mem_raddr`] sampled at the edge. A same-edge S4 write to that address returns the old data.

## Configuration
- `ALU_PIPE_FWD_EN` defined: S1 operand read uses forwarding, in priority order:
  - first, the current ALU output when S1 holds a valid instruction with matching `rd` (accepted one edge earlier);
  - then, the S2 result when S2 is valid with matching `rd`;
  - otherwise, the register bank.
  - Back-to-back dependent instructions see the architecturally correct value.
- Undefined: operands come from the register bank only. A dependent instruction issued 1 or 2 cycles after its producer reads the stale value; issue gap ≥3 is correct.

## Test plan
- Init R[k]=k via cfg. Issue add r3,r5→r10, addr 125, then 3 idle cycles -> `z`=8 two edges after accept; R[10]=8; M[125]=8 at edge k+3.
- Back-to-back sequence:
  - add r3,r5→r10 @125
  - mul r3,r8→r12 @126
  - sub r10,r5→r14 @128
  - shl(func 11) r7→r13 @127
  - With FWD: M[125..128] = 8, 24, 14, 3. Without FWD: M[128] = 5.
- `cfg_data`=300 into r1; mul r1,r1→r2 -> `z`=24464 (90000 mod 65536); sub r0,r1 -> 65236.
- Assert `hold` for 3 cycles with 3 instructions in flight -> `in_ready`=0, `z` stable, no register/memory change. On release, results resume in order with unchanged values.
- Assert `rst_n`=0 one cycle after accept -> `z`=0 and `z_valid`=0 immediately; destination register and memory address keep their prior contents.
- Same-edge S3 writeback to r10 and `cfg_we` to r10 -> R[10] = ALU result. Also `func` 12–15 -> `z`=0.

Source files
------------

// File: rtl/alu_pipe_param.sv
// Four-stage register-read / ALU / writeback / store pipeline with hold and cfg write port.
// Define ALU_PIPE_FWD_EN to forward S1/S2 results into the operand read.
module alu_pipe_param #(
    parameter int unsigned DW = 16,
    parameter int unsigned RA = 4,
    parameter int unsigned MA = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          hold,
    input  logic [RA-1:0] rs1,
    input  logic [RA-1:0] rs2,
    input  logic [RA-1:0] rd,
    input  logic [3:0]    func,
    input  logic [MA-1:0] addr,
    output logic [DW-1:0] z,
    output logic          z_valid,
    input  logic          cfg_we,
    input  logic [RA-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_data,
    input  logic [MA-1:0] mem_raddr,
    output logic [DW-1:0] mem_rdata
);

    localparam int unsigned NREG = 1 << RA;
    localparam int unsigned NMEM = 1 << MA;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_MUL    = 4'd2,
        ALU_PASS_A = 4'd3,
        ALU_PASS_B = 4'd4,
        ALU_AND    = 4'd5,
        ALU_OR     = 4'd6,
        ALU_XOR    = 4'd7,
        ALU_NEG_A  = 4'd8,
        ALU_NEG_B  = 4'd9,
        ALU_SHR    = 4'd10,
        ALU_SHL    = 4'd11
    } alu_op_t;

    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] mem  [NMEM];

    logic          s1_valid;
    logic [DW-1:0] s1_a;
    logic [DW-1:0] s1_b;
    logic [RA-1:0] s1_rd;
    logic [3:0]    s1_func;
    logic [MA-1:0] s1_addr;

    logic [RA-1:0] s2_rd;
    logic [MA-1:0] s2_addr;

    logic          s3_valid;
    logic [DW-1:0] s3_z;
    logic [MA-1:0] s3_addr;

    logic [DW-1:0] alu_y;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          wb_en;
    logic          mem_we;

    assign in_ready = ~hold;
    assign wb_en    = z_valid & ~hold;
    assign mem_we   = s3_valid & ~hold;

    always_comb begin
        alu_y = '0;
        case (s1_func)
            ALU_ADD:    alu_y = s1_a + s1_b;
            ALU_SUB:    alu_y = s1_a - s1_b;
            ALU_MUL:    alu_y = s1_a * s1_b;
            ALU_PASS_A: alu_y = s1_a;
            ALU_PASS_B: alu_y = s1_b;
            ALU_AND:    alu_y = s1_a & s1_b;
            ALU_OR:     alu_y = s1_a | s1_b;
            ALU_XOR:    alu_y = s1_a ^ s1_b;
            ALU_NEG_A:  alu_y = '0 - s1_a;
            ALU_NEG_B:  alu_y = '0 - s1_b;
            ALU_SHR:    alu_y = s1_a >> 1;
            ALU_SHL:    alu_y = s1_a << 1;
            default:    alu_y = '0;
        endcase
    end

`ifdef ALU_PIPE_FWD_EN
    // S2 must be forwarded too: its writeback lands on the same edge as this read.
    always_comb begin
        op_a = regs[rs1];
        if (s1_valid && (s1_rd == rs1))
            op_a = alu_y;
        else if (z_valid && (s2_rd == rs1))
            op_a = z;

        op_b = regs[rs2];
        if (s1_valid && (s1_rd == rs2))
            op_b = alu_y;
        else if (z_valid && (s2_rd == rs2))
            op_b = z;
    end
`else
    always_comb begin
        op_a = regs[rs1];
        op_b = regs[rs2];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_rd    <= '0;
            s1_func  <= '0;
            s1_addr  <= '0;
            z_valid  <= 1'b0;
            z        <= '0;
            s2_rd    <= '0;
            s2_addr  <= '0;
            s3_valid <= 1'b0;
            s3_z     <= '0;
            s3_addr  <= '0;
        end else if (!hold) begin
            s1_valid <= in_valid;
            s1_a     <= op_a;
            s1_b     <= op_b;
            s1_rd    <= rd;
            s1_func  <= func;
            s1_addr  <= addr;
            z_valid  <= s1_valid;
            z        <= alu_y;
            s2_rd    <= s1_rd;
            s2_addr  <= s1_addr;
            s3_valid <= z_valid;
            s3_z     <= z;
            s3_addr  <= s2_addr;
        end
    end

    // Pipeline writeback takes priority over a cfg write to the same register.
    always_ff @(posedge clk) begin
        if (cfg_we && !(wb_en && (s2_rd == cfg_addr)))
            regs[cfg_addr] <= cfg_data;
        if (wb_en)
            regs[s2_rd] <= z;
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[s3_addr] <= s3_z;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_rdata <= '0;
        else
            mem_rdata <= mem[mem_raddr];
    end

endmodule
